// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions, FSM encoding and the reset baud divisor.
package uart_tx_periph_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int DIV_RESET_DEFAULT = 434;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  // A zero divisor would stall the baud counter, so it is stored as 1.
  function automatic logic [15:0] sanitize_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Synchronous FIFO feeding the UART serializer; a push while full is accepted
// only when a pop happens in the same cycle, otherwise it is reported as dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage has no reset; the pointers and count define validity, so
  // clearing the array would only add reset fanout.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter and
// frame FSM. Define UART_TX_PERIPH_IRQ_EN to add irq_o and a writable CTRL.irq_en.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o
`ifdef UART_TX_PERIPH_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  sel;
  logic        wr_txdata, wr_status, wr_div, wr_ctrl;
  logic [15:0] divisor_q, divisor_d;
  logic        tx_en_q, tx_en_d, ovf_q, ovf_d;
  logic        irq_en_q;

  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty, fifo_drop, fifo_pop;
  logic [CW-1:0] fifo_count;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d, div_lat_q, div_lat_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        start_ok, baud_done, busy;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  assign sel       = addr_i[3:2];
  assign wr_txdata = wr_en_i && (sel == REG_TXDATA);
  assign wr_status = wr_en_i && (sel == REG_STATUS);
  assign wr_div    = wr_en_i && (sel == REG_DIVISOR);
  assign wr_ctrl   = wr_en_i && (sel == REG_CTRL);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_txdata),
    .data_i  (data_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    divisor_d = divisor_q;
    tx_en_d   = tx_en_q;
    ovf_d     = ovf_q;
    if (wr_div)  divisor_d = sanitize_div(data_i[15:0]);
    if (wr_ctrl) tx_en_d = data_i[CTRL_TX_EN];
    if (fifo_drop) ovf_d = 1'b1;
    else if (wr_status && data_i[ST_OVF]) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divisor_q <= 16'(DIV_RESET);
      tx_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      divisor_q <= divisor_d;
      tx_en_q   <= tx_en_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef UART_TX_PERIPH_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= data_i[CTRL_IRQ_EN];
      irq_q <= irq_en_q && (fifo_empty || ovf_q);
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_en_q = 1'b0;
`endif

  // Frame FSM: state register, next-state logic, output logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
    end
  end

  assign start_ok  = tx_en_q && !fifo_empty;
  assign baud_done = (baud_q == 16'd0);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    fifo_pop  = 1'b0;
    if (state_q != S_IDLE && !baud_done) begin
      baud_d = baud_q - 16'd1;
    end else begin
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          baud_d  = div_lat_q - 16'd1;
          bit_d   = 3'd0;
        end
        S_DATA: begin
          baud_d = div_lat_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
        default: begin
          // IDLE, or the last STOP cycle: chain straight into the next frame.
          state_d = S_IDLE;
          if (start_ok) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            div_lat_d = divisor_q;
            baud_d    = divisor_q - 16'd1;
            state_d   = S_START;
          end
        end
      endcase
    end
  end

  always_comb begin
    tx_o = 1'b1;
    busy = (state_q != S_IDLE);
    case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  always_comb begin
    data_o = '0;
    if (rd_en_i) begin
      case (sel)
        REG_STATUS:  data_o[7:0] = {4'(fifo_count), ovf_q, fifo_empty, fifo_full, busy};
        REG_DIVISOR: data_o[15:0] = divisor_q;
        REG_CTRL:    data_o[1:0] = {irq_en_q, tx_en_q};
        default:     data_o = '0;
      endcase
    end
  end

endmodule
